// File: rtl/ame_matrix_builder.sv
// rtl/ame_matrix_builder.sv - streaming accumulator building the 6x7 affine normal-equation system (A | B)
// Define AME_MATRIX_BUILDER_SAT_EN for saturating accumulation; otherwise accumulators wrap.
module ame_matrix_builder #(
    parameter int COMP_DATA_BITS = 64,
    parameter int GRAD_BITS      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                affine_param6_i,
    input  logic                                samp_valid_i,
    output logic                                samp_ready_o,
    input  logic                                samp_last_i,
    input  logic [5:0][GRAD_BITS-1:0]           samp_grad_i,
    input  logic [GRAD_BITS-1:0]                samp_resid_i,
    output logic                                comp_init_o,
    input  logic                                comp_done_i,
    output logic                                affine_param6_o,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0] comp_data_o
);

    localparam int NUM_A     = 21;
    localparam int NUM_E     = 27;
    localparam int PROD_BITS = 2 * GRAD_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    state_e state_q, state_d;
    logic   flush_cnt_q, flush_cnt_d;
    logic   param6_q, param6_d;
    logic   s1_valid_q, s1_valid_d;
    logic   accept;
    logic   block_start;

    logic signed [PROD_BITS-1:0]      prod_q [NUM_E];
    logic signed [PROD_BITS-1:0]      prod_d [NUM_E];
    logic signed [COMP_DATA_BITS-1:0] acc_q  [NUM_E];
    logic signed [COMP_DATA_BITS-1:0] acc_d  [NUM_E];
    logic signed [COMP_DATA_BITS-1:0] ext;
    logic signed [COMP_DATA_BITS-1:0] sum;
    logic signed [COMP_DATA_BITS-1:0] cur;

`ifdef AME_MATRIX_BUILDER_SAT_EN
    localparam logic signed [COMP_DATA_BITS-1:0] SAT_MAX = {1'b0, {(COMP_DATA_BITS-1){1'b1}}};
    localparam logic signed [COMP_DATA_BITS-1:0] SAT_MIN = {1'b1, {(COMP_DATA_BITS-1){1'b0}}};
    logic [NUM_E-1:0] sat_q, sat_d;
`endif

    // Storage slot 0..20 is the row-major upper triangle of A, 21..26 is B; j < i mirrors onto (j, i).
    function automatic logic [4:0] elem_idx(input int i, input int j);
        int a;
        int b;
        if (j == 6) begin
            return 5'(NUM_A + i);
        end
        a = (i <= j) ? i : j;
        b = (i <= j) ? j : i;
        return 5'(a * 6 - (a * (a - 1)) / 2 + (b - a));
    endfunction

    assign accept      = samp_valid_i & samp_ready_o;
    assign block_start = accept & (state_q == ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = 1'b0;
        case (state_q)
            ST_IDLE:  if (accept) state_d = samp_last_i ? ST_FLUSH : ST_ACCUM;
            ST_ACCUM: if (accept && samp_last_i) state_d = ST_FLUSH;
            ST_FLUSH: begin
                // Two drain cycles: one for the product stage, one for the accumulate stage.
                flush_cnt_d = ~flush_cnt_q;
                if (flush_cnt_q) state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (comp_done_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        samp_ready_o = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
        comp_init_o  = (state_q == ST_ISSUE);
    end

    always_comb begin
        s1_valid_d = accept;
        prod_d     = prod_q;
        if (accept) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = i; j < 6; j++) begin
                    prod_d[elem_idx(i, j)] = PROD_BITS'($signed(samp_grad_i[i]))
                                           * PROD_BITS'($signed(samp_grad_i[j]));
                end
                prod_d[elem_idx(i, 6)] = PROD_BITS'($signed(samp_grad_i[i]))
                                       * PROD_BITS'($signed(samp_resid_i));
            end
        end
    end

    always_comb begin
        param6_d = block_start ? affine_param6_i : param6_q;
        acc_d    = acc_q;
        ext      = '0;
        sum      = '0;
        cur      = '0;
`ifdef AME_MATRIX_BUILDER_SAT_EN
        sat_d    = sat_q;
`endif
        if (block_start) begin
            for (int k = 0; k < NUM_E; k++) acc_d[k] = '0;
`ifdef AME_MATRIX_BUILDER_SAT_EN
            sat_d = '0;
`endif
        end else if (s1_valid_q) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = i; j < 7; j++) begin
                    // 4-parameter blocks never touch rows/columns 0..1.
                    if (param6_q || i >= 2) begin
                        cur = acc_q[elem_idx(i, j)];
                        ext = COMP_DATA_BITS'(prod_q[elem_idx(i, j)]);
                        sum = cur + ext;
`ifdef AME_MATRIX_BUILDER_SAT_EN
                        if (!sat_q[elem_idx(i, j)]) begin
                            if (cur[COMP_DATA_BITS-1] == ext[COMP_DATA_BITS-1] &&
                                sum[COMP_DATA_BITS-1] != cur[COMP_DATA_BITS-1]) begin
                                acc_d[elem_idx(i, j)] = ext[COMP_DATA_BITS-1] ? SAT_MIN : SAT_MAX;
                                sat_d[elem_idx(i, j)] = 1'b1;
                            end else begin
                                acc_d[elem_idx(i, j)] = sum;
                            end
                        end
`else
                        acc_d[elem_idx(i, j)] = sum;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            param6_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            for (int k = 0; k < NUM_E; k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
            end
`ifdef AME_MATRIX_BUILDER_SAT_EN
            sat_q      <= '0;
`endif
        end else begin
            param6_q   <= param6_d;
            s1_valid_q <= s1_valid_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
`ifdef AME_MATRIX_BUILDER_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    always_comb begin
        comp_data_o = '0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 7; j++) begin
                comp_data_o[i][j] = acc_q[elem_idx(i, j)];
            end
        end
    end

    assign affine_param6_o = param6_q;

endmodule

// File: tb/tb_ame_matrix_builder.sv
// tb/tb_ame_matrix_builder.sv - scoreboard testbench for ame_matrix_builder
module tb_ame_matrix_builder;

    localparam int CDB = 32;
    localparam int GB  = 16;

    typedef logic [5:0][6:0][CDB-1:0] mat_t;
    typedef struct packed {
        logic [5:0][GB-1:0] g;
        logic [GB-1:0]      r;
    } smp_t;
    typedef struct packed {
        mat_t m;
        logic p6;
        int   init_cyc;
    } exp_t;

    logic               clk_i;
    logic               rst_n_i;
    logic               affine_param6_i;
    logic               samp_valid_i;
    logic               samp_ready_o;
    logic               samp_last_i;
    logic [5:0][GB-1:0] samp_grad_i;
    logic [GB-1:0]      samp_resid_i;
    logic               comp_init_o;
    logic               comp_done_i;
    logic               affine_param6_o;
    mat_t               comp_data_o;

    ame_matrix_builder #(
        .COMP_DATA_BITS(CDB),
        .GRAD_BITS     (GB)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .affine_param6_i(affine_param6_i),
        .samp_valid_i   (samp_valid_i),
        .samp_ready_o   (samp_ready_o),
        .samp_last_i    (samp_last_i),
        .samp_grad_i    (samp_grad_i),
        .samp_resid_i   (samp_resid_i),
        .comp_init_o    (comp_init_o),
        .comp_done_i    (comp_done_i),
        .affine_param6_o(affine_param6_o),
        .comp_data_o    (comp_data_o)
    );

    int   cyc = 0;
    int   n_acc = 0;
    int   last_acc_edge = -1;
    int   n_init = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    smp_t blk[$];
    exp_t sb[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_n_i && samp_valid_i && samp_ready_o) begin
            n_acc         <= n_acc + 1;
            last_acc_edge <= cyc + 1;
        end
        if (comp_init_o) n_init <= n_init + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic smp_t mk_smp(input int c0, input int c1, input int c2, input int c3,
                                    input int c4, input int c5, input int r);
        smp_t s;
        s.g[0] = GB'(c0);
        s.g[1] = GB'(c1);
        s.g[2] = GB'(c2);
        s.g[3] = GB'(c3);
        s.g[4] = GB'(c4);
        s.g[5] = GB'(c5);
        s.r    = GB'(r);
        return s;
    endfunction

    // Exact full-matrix sums in 64-bit, then the mode mask and the CDB-bit wrap or clamp.
    function automatic mat_t model(input bit p6);
        longint ex[6][7];
        longint v;
        longint mx;
        longint mn;
        mat_t   m;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++) ex[i][j] = 0;
        foreach (blk[s]) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++)
                    ex[i][j] += longint'($signed(blk[s].g[i])) * longint'($signed(blk[s].g[j]));
                ex[i][6] += longint'($signed(blk[s].g[i])) * longint'($signed(blk[s].r));
            end
        end
        mx = (64'sd1 <<< (CDB - 1)) - 1;
        mn = -mx - 1;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 7; j++) begin
                v = (!p6 && (i < 2 || j < 2)) ? 64'sd0 : ex[i][j];
`ifdef AME_MATRIX_BUILDER_SAT_EN
                if (v > mx) v = mx;
                if (v < mn) v = mn;
`endif
                m[i][j] = v[CDB-1:0];
            end
        end
        return m;
    endfunction

    task automatic drive_wait(output int e);
        int guard;
        guard = 0;
        @(negedge clk_i);
        while (!samp_ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        n_checks++;
        if (!samp_ready_o) begin
            n_fail++;
            $display("FAIL accept_timeout: samp_ready_o=%0b required 1", samp_ready_o);
        end
        @(posedge clk_i);
        #1;
        e = cyc;
        samp_valid_i = 1'b0;
    endtask

    task automatic send_block(input bit p6, input int max_bubble);
        int e;
        e = 0;
        foreach (blk[s]) begin
            if (s > 0 && max_bubble > 0) begin
                repeat ($urandom_range(0, max_bubble)) begin
                    samp_valid_i = 1'b0;
                    @(posedge clk_i);
                    #1;
                end
            end
            affine_param6_i = p6;
            samp_grad_i     = blk[s].g;
            samp_resid_i    = blk[s].r;
            samp_last_i     = (s == blk.size() - 1);
            samp_valid_i    = 1'b1;
            drive_wait(e);
        end
        sb.push_back('{m: model(p6), p6: p6, init_cyc: e + 2});
    endtask

    task automatic check_block(input string name);
        int   guard;
        exp_t ex;
        bit   found;
        guard = 0;
        found = 0;
        @(negedge clk_i);
        while (!comp_init_o && guard < 40) begin
            @(negedge clk_i);
            guard++;
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s sb_empty: no expected block queued", name);
        end else begin
            ex = sb.pop_front();
            n_checks++;
            if (!comp_init_o || cyc != ex.init_cyc) begin
                n_fail++;
                $display("FAIL %s init_cycle: comp_init_o=%0b at cycle %0d, required 1 at cycle %0d",
                         name, comp_init_o, cyc, ex.init_cyc);
            end
            n_checks++;
            if (comp_data_o !== ex.m) begin
                n_fail++;
                for (int i = 0; i < 6; i++)
                    for (int j = 0; j < 7; j++)
                        if (!found && comp_data_o[i][j] !== ex.m[i][j]) begin
                            found = 1;
                            $display("FAIL %s matrix[%0d][%0d]: got %h required %h",
                                     name, i, j, comp_data_o[i][j], ex.m[i][j]);
                        end
            end
            n_checks++;
            if (affine_param6_o !== ex.p6) begin
                n_fail++;
                $display("FAIL %s affine_param6_o: got %0b required %0b", name, affine_param6_o, ex.p6);
            end
        end
        @(negedge clk_i);
        n_checks++;
        if (comp_init_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s init_width: comp_init_o=%0b required 0", name, comp_init_o);
        end
    endtask

    task automatic release_solver(input int d);
        repeat (d) begin
            @(posedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        comp_done_i = 1'b1;
        @(posedge clk_i);
        #1;
        comp_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i         = 1'b0;
        affine_param6_i = 1'b0;
        samp_valid_i    = 1'b0;
        samp_last_i     = 1'b0;
        samp_grad_i     = '0;
        samp_resid_i    = '0;
        comp_done_i     = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (samp_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", samp_ready_o); end
        n_checks++;
        if (comp_init_o !== 1'b0) begin n_fail++; $display("FAIL reset_init: got %0b required 0", comp_init_o); end
        n_checks++;
        if (affine_param6_o !== 1'b0) begin n_fail++; $display("FAIL reset_param6: got %0b required 0", affine_param6_o); end
        n_checks++;
        if (comp_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero required all 0"); end
        #2;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single_6p();
        blk.delete();
        blk.push_back(mk_smp(1, 1, 1, 1, 1, 1, 2));
        send_block(1'b1, 0);
        check_block("single_6p");
        n_checks++;
        if (comp_data_o[4][1] !== CDB'(1)) begin n_fail++; $display("FAIL single_A41: got %h required 1", comp_data_o[4][1]); end
        n_checks++;
        if (comp_data_o[3][6] !== CDB'(2)) begin n_fail++; $display("FAIL single_B3: got %h required 2", comp_data_o[3][6]); end
        release_solver(2);
    endtask

    task automatic test_two_6p();
        blk.delete();
        blk.push_back(mk_smp(1, 2, 3, 4, 5, 6, -1));
        blk.push_back(mk_smp(1, 2, 3, 4, 5, 6, -1));
        send_block(1'b1, 0);
        check_block("two_6p");
        n_checks++;
        if (comp_data_o[5][5] !== CDB'(72)) begin n_fail++; $display("FAIL two6_A55: got %h required 72", comp_data_o[5][5]); end
        n_checks++;
        if (comp_data_o[0][5] !== CDB'(12) || comp_data_o[5][0] !== CDB'(12)) begin
            n_fail++;
            $display("FAIL two6_A05_A50: got %h/%h required 12/12", comp_data_o[0][5], comp_data_o[5][0]);
        end
        n_checks++;
        if (comp_data_o[5][6] !== CDB'(-12)) begin n_fail++; $display("FAIL two6_B5: got %h required -12", comp_data_o[5][6]); end
        n_checks++;
        if (comp_data_o[0][6] !== CDB'(-2)) begin n_fail++; $display("FAIL two6_B0: got %h required -2", comp_data_o[0][6]); end
        release_solver(1);
    endtask

    task automatic test_two_4p();
        bit nz;
        nz = 0;
        blk.delete();
        blk.push_back(mk_smp(1, 2, 3, 4, 5, 6, -1));
        blk.push_back(mk_smp(1, 2, 3, 4, 5, 6, -1));
        send_block(1'b0, 0);
        check_block("two_4p");
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                if ((i < 2 || j < 2) && comp_data_o[i][j] !== '0) nz = 1;
        n_checks++;
        if (nz) begin n_fail++; $display("FAIL two4_zero_rows_cols: got nonzero required all 0"); end
        n_checks++;
        if (comp_data_o[5][5] !== CDB'(72)) begin n_fail++; $display("FAIL two4_A55: got %h required 72", comp_data_o[5][5]); end
        n_checks++;
        if (comp_data_o[2][3] !== CDB'(24) || comp_data_o[3][2] !== CDB'(24)) begin
            n_fail++;
            $display("FAIL two4_A23_A32: got %h/%h required 24/24", comp_data_o[2][3], comp_data_o[3][2]);
        end
        n_checks++;
        if (comp_data_o[2][6] !== CDB'(-6)) begin n_fail++; $display("FAIL two4_B2: got %h required -6", comp_data_o[2][6]); end
        n_checks++;
        if (affine_param6_o !== 1'b0) begin n_fail++; $display("FAIL two4_param6: got %0b required 0", affine_param6_o); end
        release_solver(0);
    endtask

    task automatic test_backpressure();
        mat_t snap;
        int   bad_ready;
        int   bad_data;
        int   n0;
        int   done_edge;
        smp_t held;
        bad_ready = 0;
        bad_data  = 0;
        blk.delete();
        blk.push_back(mk_smp(3, -2, 7, 1, 0, 5, 4));
        blk.push_back(mk_smp(-1, 4, 2, -6, 3, 2, -3));
        send_block(1'b1, 0);
        held            = mk_smp(9, 8, 7, 6, 5, 4, 3);
        affine_param6_i = 1'b1;
        samp_grad_i     = held.g;
        samp_resid_i    = held.r;
        samp_last_i     = 1'b1;
        samp_valid_i    = 1'b1;
        n0 = n_acc;
        check_block("bp_first");
        snap = comp_data_o;
        repeat (10) begin
            @(negedge clk_i);
            if (samp_ready_o !== 1'b0) bad_ready++;
            if (comp_data_o !== snap) bad_data++;
        end
        n_checks++;
        if (bad_ready != 0) begin n_fail++; $display("FAIL bp_wait_ready: %0d cycles ready, required 0", bad_ready); end
        n_checks++;
        if (bad_data != 0) begin n_fail++; $display("FAIL bp_wait_stable: %0d cycles changed, required 0", bad_data); end
        n_checks++;
        if (n_acc != n0) begin n_fail++; $display("FAIL bp_no_accept: accepted %0d, required 0", n_acc - n0); end
        @(posedge clk_i);
        #1;
        comp_done_i = 1'b1;
        done_edge   = cyc + 1;
        @(posedge clk_i);
        #1;
        comp_done_i = 1'b0;
        @(posedge clk_i);
        #1;
        samp_valid_i = 1'b0;
        n_checks++;
        if (n_acc != n0 + 1 || last_acc_edge != done_edge + 1) begin
            n_fail++;
            $display("FAIL bp_accept_edge: got %0d accepts at edge %0d, required 1 at edge %0d",
                     n_acc - n0, last_acc_edge, done_edge + 1);
        end
        blk.delete();
        blk.push_back(held);
        sb.push_back('{m: model(1'b1), p6: 1'b1, init_cyc: done_edge + 3});
        check_block("bp_second");
        release_solver(0);
    endtask

    task automatic test_saturation();
        logic [CDB-1:0] exp_a00;
`ifdef AME_MATRIX_BUILDER_SAT_EN
        exp_a00 = 32'h7FFF_FFFF;
`else
        exp_a00 = 32'hBFFD_0003;
`endif
        blk.delete();
        repeat (3) blk.push_back(mk_smp(32'h7FFF, 0, 0, 0, 0, 0, 0));
        send_block(1'b1, 1);
        check_block("saturation");
        n_checks++;
        if (comp_data_o[0][0] !== exp_a00) begin
            n_fail++;
            $display("FAIL sat_A00: got %h required %h", comp_data_o[0][0], exp_a00);
        end
        release_solver(1);
    endtask

    task automatic test_reset_abort();
        int e;
        int i0;
        affine_param6_i = 1'b1;
        samp_grad_i     = mk_smp(1, 1, 1, 1, 1, 1, 3).g;
        samp_resid_i    = GB'(3);
        samp_last_i     = 1'b0;
        repeat (3) begin
            samp_valid_i = 1'b1;
            drive_wait(e);
        end
        n_checks++;
        if (comp_data_o[0][0] !== CDB'(2)) begin n_fail++; $display("FAIL abort_partial_A00: got %h required 2", comp_data_o[0][0]); end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (comp_data_o !== '0 || samp_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_async_clear: data nonzero=%0b ready=%0b required 0/1", comp_data_o !== '0, samp_ready_o);
        end
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b1;
        i0 = n_init;
        repeat (8) @(negedge clk_i);
        n_checks++;
        if (n_init != i0) begin n_fail++; $display("FAIL abort_no_init: got %0d pulses required 0", n_init - i0); end
        @(posedge clk_i);
        #1;
        blk.delete();
        blk.push_back(mk_smp(2, 2, 2, 2, 2, 2, 1));
        send_block(1'b1, 0);
        check_block("after_abort");
        n_checks++;
        if (comp_data_o[3][4] !== CDB'(4)) begin n_fail++; $display("FAIL abort_A34: got %h required 4", comp_data_o[3][4]); end
        n_checks++;
        if (comp_data_o[2][6] !== CDB'(2)) begin n_fail++; $display("FAIL abort_B2: got %h required 2", comp_data_o[2][6]); end
        release_solver(0);
    endtask

    task automatic test_back_to_back();
        int len;
        bit p6;
        for (int b = 0; b < 4; b++) begin
            blk.delete();
            len = $urandom_range(1, 5);
            p6  = 1'($urandom_range(0, 1));
            repeat (len)
                blk.push_back(mk_smp($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                                     $urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                                     $urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                                     $urandom_range(0, 200) - 100));
            send_block(p6, 1);
            check_block("random_block");
            release_solver($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single_6p();
        test_two_6p();
        test_two_4p();
        test_backpressure();
        test_saturation();
        test_reset_abort();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d blocks never issued, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
